result_uart_tx: RTL and testbench

RESULT_UART_TX -- requirements
Module: result_uart_tx

---
 rtl/result_uart_tx.sv | 198 +++++++++++++++++++
 tb/tb_result_uart_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_uart_tx.sv
// result_uart_tx: serialises the 16 systolic-array results over an 8N1 UART line.
// Frame: C0..C15, each element most-significant byte first, bytes back-to-back.
// Optional macro RESULT_TX_HEADER_EN adds a 0xA5 header byte and a trailing
// modulo-256 checksum of the payload bytes.
module result_uart_tx #(
  parameter int unsigned REG_WIDTH    = 8,
  parameter int unsigned OUT_WIDTH    = REG_WIDTH * 2,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    done,
  input  logic [16*OUT_WIDTH-1:0] results,
  output logic                    tx,
  output logic                    busy,
  output logic                    frame_sent,
  output logic                    overrun
);

  localparam int unsigned BYTES_PER_ELEM = OUT_WIDTH / 8;
  localparam int unsigned PAYLOAD_BYTES  = 16 * BYTES_PER_ELEM;
`ifdef RESULT_TX_HEADER_EN
  localparam int unsigned FRAME_BYTES    = PAYLOAD_BYTES + 2;
`else
  localparam int unsigned FRAME_BYTES    = PAYLOAD_BYTES;
`endif
  localparam int unsigned BYTE_W         = $clog2(FRAME_BYTES);
  localparam int unsigned CNT_W          = $clog2(CLKS_PER_BIT);
  localparam int unsigned RES_W          = 16 * OUT_WIDTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_n;
  logic [2:0]        bit_idx_q, bit_idx_n;
  logic [BYTE_W-1:0] byte_idx_q, byte_idx_n;
  logic              done_q;
  logic [RES_W-1:0]  buf_q;
  logic              done_rise_c;
  logic              capture_c;
  logic              bit_end_c;
  logic              tx_n, busy_n, frame_sent_n, overrun_n;
  logic [BYTE_W-1:0] pay_idx_c;
  int unsigned       pay_pos_c;
  int unsigned       pay_off_c;
  logic [7:0]        pay_byte_c;
  logic [7:0]        cur_byte_c;
`ifdef RESULT_TX_HEADER_EN
  logic [7:0]        sum_q, sum_n;
`endif

  assign done_rise_c = done & ~done_q;
  assign bit_end_c   = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // Byte currently on the wire: payload byte from the capture buffer, or header/checksum.
  always_comb begin
`ifdef RESULT_TX_HEADER_EN
    pay_idx_c = byte_idx_q - BYTE_W'(1);
`else
    pay_idx_c = byte_idx_q;
`endif
    pay_pos_c  = 32'(pay_idx_c);
    pay_off_c  = ((pay_pos_c / BYTES_PER_ELEM) * BYTES_PER_ELEM
                 + (BYTES_PER_ELEM - 1 - (pay_pos_c % BYTES_PER_ELEM))) * 8;
    pay_byte_c = 8'(buf_q >> pay_off_c);
`ifdef RESULT_TX_HEADER_EN
    if (byte_idx_q == '0)
      cur_byte_c = 8'hA5;
    else if (byte_idx_q == BYTE_W'(FRAME_BYTES - 1))
      cur_byte_c = sum_q;
    else
      cur_byte_c = pay_byte_c;
`else
    cur_byte_c = pay_byte_c;
`endif
  end

  // Next-state, counter and next-output logic.
  always_comb begin
    state_n    = state_q;
    clk_cnt_n  = clk_cnt_q;
    bit_idx_n  = bit_idx_q;
    byte_idx_n = byte_idx_q;
    capture_c  = 1'b0;
`ifdef RESULT_TX_HEADER_EN
    sum_n      = sum_q;
`endif
    case (state_q)
      IDLE: begin
        clk_cnt_n  = '0;
        bit_idx_n  = '0;
        byte_idx_n = '0;
`ifdef RESULT_TX_HEADER_EN
        sum_n      = '0;
`endif
        if (done_rise_c) begin
          capture_c = 1'b1;
          state_n   = START;
        end
      end
      START: begin
        if (bit_end_c) begin
          clk_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          clk_cnt_n = clk_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end_c) begin
          clk_cnt_n = '0;
          if (bit_idx_q == 3'd7)
            state_n = STOP;
          else
            bit_idx_n = bit_idx_q + 3'd1;
        end else begin
          clk_cnt_n = clk_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end_c) begin
          clk_cnt_n = '0;
`ifdef RESULT_TX_HEADER_EN
          if (byte_idx_q != '0 && byte_idx_q != BYTE_W'(FRAME_BYTES - 1))
            sum_n = sum_q + cur_byte_c;
`endif
          if (byte_idx_q == BYTE_W'(FRAME_BYTES - 1)) begin
            state_n = DONE;
          end else begin
            byte_idx_n = byte_idx_q + BYTE_W'(1);
            state_n    = START;
          end
        end else begin
          clk_cnt_n = clk_cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        byte_idx_n = '0;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = cur_byte_c[bit_idx_n];
      default: tx_n = 1'b1;
    endcase
    busy_n       = (state_n == START) || (state_n == DATA) || (state_n == STOP);
    frame_sent_n = (state_n == DONE);
    overrun_n    = overrun | (done_rise_c & (state_q != IDLE));
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      done_q     <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_sent <= 1'b0;
      overrun    <= 1'b0;
`ifdef RESULT_TX_HEADER_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_n;
      clk_cnt_q  <= clk_cnt_n;
      bit_idx_q  <= bit_idx_n;
      byte_idx_q <= byte_idx_n;
      done_q     <= done;
      tx         <= tx_n;
      busy       <= busy_n;
      frame_sent <= frame_sent_n;
      overrun    <= overrun_n;
`ifdef RESULT_TX_HEADER_EN
      sum_q      <= sum_n;
`endif
    end
  end

  // Result snapshot taken on an accepted done edge; held for the whole frame.
  always_ff @(posedge clk) begin
    if (capture_c)
      buf_q <= results;
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx with CLKS_PER_BIT=4 and 16-bit result elements.
module tb_result_uart_tx;

  localparam int unsigned OW   = 16;
  localparam int unsigned CPB  = 4;
  localparam int unsigned NPAY = 32;
`ifdef RESULT_TX_HEADER_EN
  localparam int unsigned HDR  = 1;
  localparam int unsigned NB   = NPAY + 2;
`else
  localparam int unsigned HDR  = 0;
  localparam int unsigned NB   = NPAY;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            done;
  logic [16*OW-1:0] results;
  logic            tx, busy, frame_sent, overrun;

  logic [7:0] rxb  [NB];
  logic [9:0] rxlv [NB];
  int         rx_ok;
  int         busy_drop;
  int         passed = 0;
  int         failed = 0;
  int         total  = 0;
  int         cnt;
  bit         ok;

  always #5 clk = ~clk;

  result_uart_tx #(
    .REG_WIDTH   (8),
    .OUT_WIDTH   (OW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .done      (done),
    .results   (results),
    .tx        (tx),
    .busy      (busy),
    .frame_sent(frame_sent),
    .overrun   (overrun)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_busy(output bit found);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (busy === 1'b1) found = 1'b1;
    end
  endtask

  task automatic start_frame;
    done = 1'b0;
    tick();
    tick();
    done = 1'b1;
  endtask

  // Samples every cycle of the frame, starting at the busy-rise cycle already sampled.
  task automatic recv_frame(input int glitch_at);
    int g;
    logic [9:0] lv;
    bit stable;
    g = 0;
    rx_ok = 0;
    busy_drop = 0;
    for (int k = 0; k < NB; k++) begin
      stable = 1'b1;
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < CPB; c++) begin
          if (k != 0 || b != 0 || c != 0) begin
            tick();
            g++;
            if (glitch_at > 0 && g == glitch_at) done = 1'b0;
            if (glitch_at > 0 && g == glitch_at + 2) done = 1'b1;
          end
          if (busy !== 1'b1) busy_drop++;
          if (c == 0) lv[b] = tx;
          else if (tx !== lv[b]) stable = 1'b0;
        end
      end
      rxlv[k] = lv;
      rxb[k]  = lv[8:1];
      if (stable && lv[0] === 1'b0 && lv[9] === 1'b1) rx_ok++;
    end
  endtask

  initial begin
    reset   = 1'b1;
    done    = 1'b0;
    results = '0;
    tick();
    tick();
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_sent", 32'(frame_sent), 0);
    chk("rst_overrun", 32'(overrun), 0);
    reset = 1'b0;
    tick();
    tick();
    chk("idle_tx", 32'(tx), 1);

    // Frame A: C0=0x0102, done held high for 2000 cycles.
    results[OW-1:0] = 16'h0102;
    done = 1'b1;
    wait_busy(ok);
    chk("A_busy_rise", 32'(ok), 1);
    recv_frame(0);
    chk("A_byte0", 32'(rxb[HDR]), 32'h01);
    chk("A_byte1", 32'(rxb[HDR+1]), 32'h02);
    cnt = 0;
    for (int k = 2; k < NPAY; k++) if (rxb[HDR+k] !== 8'h00) cnt++;
    chk("A_zero_bytes", 32'(cnt), 0);
    chk("A_framing", 32'(rx_ok), NB);
    chk("A_busy_held", 32'(busy_drop), 0);
`ifdef RESULT_TX_HEADER_EN
    chk("A_header", 32'(rxb[0]), 32'hA5);
    chk("A_checksum", 32'(rxb[NB-1]), 32'h03);
`endif
    tick();
    chk("A_frame_sent", 32'(frame_sent), 1);
    chk("A_busy_fall", 32'(busy), 0);
    chk("A_tx_done", 32'(tx), 1);
    tick();
    chk("A_frame_sent_pulse", 32'(frame_sent), 0);
    cnt = 0;
    for (int i = 0; i < 2000 - (NB * 40 + 3); i++) begin
      tick();
      if (busy !== 1'b0) cnt++;
    end
    chk("A_single_frame", 32'(cnt), 0);
    chk("A_no_overrun", 32'(overrun), 0);

    // Frame B: bit timing on 0x55 and a second done edge mid-frame.
    results = '0;
    results[OW-1:0] = 16'h5500;
    start_frame();
    wait_busy(ok);
    chk("B_busy_rise", 32'(ok), 1);
    recv_frame(300);
    chk("B_bit_levels", 32'(rxlv[HDR]), 32'h2AA);
    chk("B_byte0", 32'(rxb[HDR]), 32'h55);
    chk("B_byte1", 32'(rxb[HDR+1]), 32'h00);
    chk("B_framing", 32'(rx_ok), NB);
    chk("B_busy_held", 32'(busy_drop), 0);
    tick();
    chk("B_frame_sent", 32'(frame_sent), 1);
    chk("B_overrun", 32'(overrun), 1);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (busy !== 1'b0) cnt++;
    end
    chk("B_no_second_frame", 32'(cnt), 0);

    // Frame C: results change one cycle after capture.
    results = '0;
    results[OW-1:0]     = 16'hABCD;
    results[15*OW +: OW] = 16'h1234;
    start_frame();
    wait_busy(ok);
    chk("C_busy_rise", 32'(ok), 1);
    results = '1;
    recv_frame(0);
    chk("C_byte0", 32'(rxb[HDR]), 32'hAB);
    chk("C_byte1", 32'(rxb[HDR+1]), 32'hCD);
    chk("C_byte2", 32'(rxb[HDR+2]), 32'h00);
    chk("C_byte30", 32'(rxb[HDR+30]), 32'h12);
    chk("C_byte31", 32'(rxb[HDR+31]), 32'h34);
    chk("C_framing", 32'(rx_ok), NB);
`ifdef RESULT_TX_HEADER_EN
    chk("C_checksum", 32'(rxb[NB-1]), 32'hBE);
`endif
    tick();
    chk("C_frame_sent", 32'(frame_sent), 1);

    // Frame D: reset during byte 5, then a fresh frame.
    results = '0;
    results[OW-1:0] = 16'h8001;
    start_frame();
    wait_busy(ok);
    chk("D_busy_rise", 32'(ok), 1);
    repeat (220) tick();
    chk("D_tx_mid_byte5", 32'(tx), 0);
    reset = 1'b1;
    #1;
    chk("D_rst_tx", 32'(tx), 1);
    chk("D_rst_busy", 32'(busy), 0);
    chk("D_rst_overrun", 32'(overrun), 0);
    chk("D_rst_frame_sent", 32'(frame_sent), 0);
    done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("D_no_resume", 32'(busy), 0);
    done = 1'b1;
    wait_busy(ok);
    chk("D_restart", 32'(ok), 1);
    recv_frame(0);
    chk("D_byte0", 32'(rxb[HDR]), 32'h80);
    chk("D_byte1", 32'(rxb[HDR+1]), 32'h01);
    chk("D_framing", 32'(rx_ok), NB);
    tick();
    chk("D_frame_sent", 32'(frame_sent), 1);

`ifdef RESULT_TX_HEADER_EN
    // Frame E: header and checksum wraparound.
    results = '0;
    results[OW-1:0]  = 16'h00FF;
    results[OW +: OW] = 16'h0001;
    start_frame();
    wait_busy(ok);
    chk("E_busy_rise", 32'(ok), 1);
    recv_frame(0);
    chk("E_header", 32'(rxb[0]), 32'hA5);
    chk("E_byte1", 32'(rxb[1]), 32'h00);
    chk("E_byte2", 32'(rxb[2]), 32'hFF);
    chk("E_byte3", 32'(rxb[3]), 32'h00);
    chk("E_byte4", 32'(rxb[4]), 32'h01);
    chk("E_checksum", 32'(rxb[33]), 32'h00);
    chk("E_framing", 32'(rx_ok), 34);
    tick();
    chk("E_frame_sent", 32'(frame_sent), 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
